pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB).
- Consumes register identifiers and control bits already carried by the ID/EX and EX/MEM pipeline registers.
- Produces the write-enable and bubble-insert controls those same registers and the PC consume.
- Handles data hazards, taken-branch flushes, data-memory busy, and halt draining.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_rd1_reg  in  3  ID source register 1
- id_rd1_used  in  1  ID instruction reads source 1
- id_rd2_reg  in  3  ID source register 2
- id_rd2_used  in  1  ID instruction reads source 2
- ex_write_reg  in  3  EX destination register
- ex_regWrite  in  1  EX instruction writes the register file
- ex_memRead  in  1  EX instruction is a load
- mem_write_reg  in  3  MEM destination register
- mem_regWrite  in  1  MEM instruction writes the register file
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- ex_halt  in  1  halt instruction in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_wr_en  out  1  PC update enable
- if_id_wr_en  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_wr_en  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits zero)
- ex_mem_wr_en  out  1  EX/MEM write enable
- mem_wb_wr_en  out  1  MEM/WB write enable
- halted  out  1  pipeline fully drained after halt
- stall_cnt  out  CNT_W  saturating count of bubble and freeze cycles

## Operation
- States: RUN, MEM_WAIT, HALT_DRAIN, HALTED.
- Register r0 is not special: a match on r0 still counts as a hazard.
- Hazard match: (id_rd1_used & id_rd1_reg == X) | (id_rd2_used & id_rd2_reg == X), where X is the destination register of the stage being checked.
- RUN: priorities are evaluated in this order each cycle.
  1. mem_busy: freeze. All wr_en = 0 and flushes = 0. Next state MEM_WAIT.
  2. ex_halt: pc_wr_en = 0, if_id_flush = 1, id_ex_flush = 1, all wr_en = 1. Load the drain counter with 2. Next state HALT_DRAIN.
  3. ex_branch_taken: if_id_flush = 1, id_ex_flush = 1, all wr_en = 1.
  4. Data hazard: pc_wr_en = 0, if_id_wr_en = 0, id_ex_flush = 1, all other wr_en = 1.
  5. Otherwise: all wr_en = 1 and flushes = 0.
- A data hazard that coincides with a taken branch is discarded; the flush wins.
- MEM_WAIT: freeze while mem_busy = 1. When mem_busy = 0, apply the RUN decision for that same cycle and move to RUN. No cycle is lost.
- HALT_DRAIN:
  - pc_wr_en = 0, if_id_flush = 1, id_ex_flush = 1.
  - EX/MEM and MEM/WB advance unless mem_busy = 1, which freezes them.
  - The drain counter decrements only on cycles where the pipeline advances.
  - When the counter reaches 0, move to HALTED.
- HALTED: all wr_en = 0, halted = 1. Only reset exits this state.
- stall_cnt increments by 1 on every cycle in which pc_wr_en = 0, or id_ex_flush = 1 because of a data hazard. It saturates at 2^CNT_W − 1.

## Timing
- All outputs except halted and stall_cnt are combinational from the current state and the inputs.
- halted and stall_cnt are registered.
- Reset (rst = 0): state RUN, drain counter 0, halted = 0, stall_cnt = 0. All wr_en and flush outputs are forced to 0 while rst is low.
- First cycle after rst deasserts: normal RUN decision.
- Reset asserted mid-stall or mid-drain aborts immediately; there is no residual freeze.
- Branch flush costs 2 bubbles.
- Data-hazard stall lasts until the matching writer retires:
  - up to 2 cycles without forwarding;
  - exactly 1 cycle for load-use with forwarding.
- The register file writes in the first half of the cycle, so a match against the WB stage is never a hazard.

## Configuration
- PIPE_FWD_EN defined:
  - A forwarding unit exists downstream of this block.
  - A data hazard is reported only when ex_regWrite & ex_memRead & a match against ex_write_reg.
  - The MEM stage is ignored for hazard detection.
- PIPE_FWD_EN undefined:
  - A data hazard is reported on a match against EX (when ex_regWrite) or against MEM (when mem_regWrite).
  - ex_memRead is ignored.

## Structure
- Shared pipeline package holds:
  - the state encoding (2-bit localparams S_RUN = 0, S_MEM_WAIT = 1, S_HALT_DRAIN = 2, S_HALTED = 3);
  - the register-identifier width REG_W = 3;
  - DRAIN_CYC = 2.
- One sub-module: hazard_detect. It is purely combinational, takes the source and destination fields, honours PIPE_FWD_EN, and outputs a single data_hazard bit.
- The FSM, drain counter and stall counter live in pipe_hazard_ctrl.

## Test plan
- Back-to-back ALU dependency:
  - ID reads r3 (id_rd1_used = 1), EX writes r3 (ex_regWrite = 1, ex_memRead = 0).
  - Without PIPE_FWD_EN: pc_wr_en = 0 and id_ex_flush = 1 for 2 cycles, then stall_cnt = 2.
  - With PIPE_FWD_EN: no stall.
- Load-use with PIPE_FWD_EN:
  - ex_memRead = 1, ex_write_reg = 5, id_rd2_reg = 5 (id_rd2_used = 1).
  - Exactly 1 bubble; stall_cnt increments by 1.
- Taken branch coinciding with a data hazard:
  - if_id_flush = id_ex_flush = 1 and pc_wr_en = 1 for 1 cycle.
  - stall_cnt unchanged.
- mem_busy held for 3 cycles during a hazard:
  - All wr_en = 0 for 3 cycles in MEM_WAIT.
  - On release, the hazard stall proceeds.
  - stall_cnt increases by 3 + hazard cycles.
- Halt with mem_busy = 1 during the second drain cycle:
  - halted rises one cycle later than the nominal 3 cycles after ex_halt.
  - pc_wr_en stays 0 throughout.
- Reset asserted in HALT_DRAIN:
  - Outputs go to their reset values asynchronously.
  - After release: RUN, all wr_en = 1, halted = 0, stall_cnt = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline stall/flush sequencer:
// FSM state encoding, register-id width, drain length and the RUN decision table.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W     = 3;
  localparam int unsigned DRAIN_CYC = 2;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MEM_WAIT   = 2'd1,
    S_HALT_DRAIN = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_wr_en;
    logic if_id_wr_en;
    logic if_id_flush;
    logic id_ex_wr_en;
    logic id_ex_flush;
    logic ex_mem_wr_en;
    logic mem_wb_wr_en;
  } ctrl_t;

  // Priority order: memory freeze, halt, taken branch, data hazard, normal advance.
  function automatic ctrl_t run_decision(input logic busy, input logic halt,
                                         input logic branch, input logic hazard);
    ctrl_t c;
    c = '0;
    if (busy) begin
      c = '0;
    end else if (halt) begin
      c = '1;
      c.pc_wr_en = 1'b0;
    end else if (branch) begin
      c = '1;
    end else if (hazard) begin
      c = '1;
      c.pc_wr_en    = 1'b0;
      c.if_id_wr_en = 1'b0;
      c.if_id_flush = 1'b0;
    end else begin
      c = '1;
      c.if_id_flush = 1'b0;
      c.id_ex_flush = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard detector for the ID stage sources.
// Macro PIPE_FWD_EN: only load-use against EX is a hazard (forwarding covers the rest).
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rd1_reg,
  input  logic             id_rd1_used,
  input  logic [REG_W-1:0] id_rd2_reg,
  input  logic             id_rd2_used,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_regWrite,
  output logic             data_hazard
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = (id_rd1_used & (id_rd1_reg == ex_write_reg)) |
                     (id_rd2_used & (id_rd2_reg == ex_write_reg));
  assign mem_match = (id_rd1_used & (id_rd1_reg == mem_write_reg)) |
                     (id_rd2_used & (id_rd2_reg == mem_write_reg));

`ifdef PIPE_FWD_EN
  logic unused_mem;
  assign unused_mem  = mem_match ^ mem_regWrite;
  assign data_hazard = ex_regWrite & ex_memRead & ex_match;
`else
  logic unused_memread;
  assign unused_memread = ex_memRead;
  assign data_hazard    = (ex_regWrite & ex_match) | (mem_regWrite & mem_match);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: RUN / MEM_WAIT / HALT_DRAIN / HALTED FSM,
// halt drain counter and saturating stall counter. Macro PIPE_FWD_EN selects forwarding mode.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rd1_reg,
  input  logic             id_rd1_used,
  input  logic [REG_W-1:0] id_rd2_reg,
  input  logic             id_rd2_used,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_regWrite,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             mem_busy,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_wr_en,
  output logic             id_ex_flush,
  output logic             ex_mem_wr_en,
  output logic             mem_wb_wr_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               data_hazard;
  ctrl_t              ctrl;

  hazard_detect u_hazard_detect (
    .id_rd1_reg    (id_rd1_reg),
    .id_rd1_used   (id_rd1_used),
    .id_rd2_reg    (id_rd2_reg),
    .id_rd2_used   (id_rd2_used),
    .ex_write_reg  (ex_write_reg),
    .ex_regWrite   (ex_regWrite),
    .ex_memRead    (ex_memRead),
    .mem_write_reg (mem_write_reg),
    .mem_regWrite  (mem_regWrite),
    .data_hazard   (data_hazard)
  );

  // MEM_WAIT shares the RUN table: busy keeps freezing, release resumes in the same cycle.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      unique case (state)
        S_RUN, S_MEM_WAIT: ctrl = run_decision(mem_busy, ex_halt, ex_branch_taken, data_hazard);
        S_HALT_DRAIN: begin
          ctrl              = '1;
          ctrl.pc_wr_en     = 1'b0;
          ctrl.ex_mem_wr_en = ~mem_busy;
          ctrl.mem_wb_wr_en = ~mem_busy;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_wr_en     = ctrl.pc_wr_en;
  assign if_id_wr_en  = ctrl.if_id_wr_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_wr_en  = ctrl.id_ex_wr_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_wr_en = ctrl.ex_mem_wr_en;
  assign mem_wb_wr_en = ctrl.mem_wb_wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // A hazard bubble always coincides with a held PC, so pc_wr_en alone drives the count.
      if (!ctrl.pc_wr_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      unique case (state)
        S_RUN, S_MEM_WAIT: begin
          if (mem_busy) begin
            state <= S_MEM_WAIT;
          end else if (ex_halt) begin
            state     <= S_HALT_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYC);
          end else begin
            state <= S_RUN;
          end
        end
        S_HALT_DRAIN: begin
          if (!mem_busy) begin
            if (drain_cnt <= DRAIN_W'(1)) begin
              drain_cnt <= '0;
              state     <= S_HALTED;
              halted    <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        default: begin
          state  <= S_HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    id_rd1_reg, id_rd2_reg, ex_write_reg, mem_write_reg;
  logic          id_rd1_used, id_rd2_used, ex_regWrite, ex_memRead, mem_regWrite;
  logic          ex_branch_taken, ex_halt, mem_busy;
  logic          pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush;
  logic          ex_mem_wr_en, mem_wb_wr_en, halted;
  logic [CW-1:0] stall_cnt;
  logic [6:0]    act;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 run, 1 mem wait, 2 drain, 3 halted
  int m_st, m_drain, m_cnt;
  bit m_halted;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rd1_reg(id_rd1_reg), .id_rd1_used(id_rd1_used),
    .id_rd2_reg(id_rd2_reg), .id_rd2_used(id_rd2_used),
    .ex_write_reg(ex_write_reg), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .mem_write_reg(mem_write_reg), .mem_regWrite(mem_regWrite),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .mem_busy(mem_busy),
    .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
    .id_ex_wr_en(id_ex_wr_en), .id_ex_flush(id_ex_flush),
    .ex_mem_wr_en(ex_mem_wr_en), .mem_wb_wr_en(mem_wb_wr_en),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  assign act = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush,
                ex_mem_wr_en, mem_wb_wr_en};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit reads(input logic [2:0] r);
    return (id_rd1_used && id_rd1_reg == r) || (id_rd2_used && id_rd2_reg == r);
  endfunction

  function automatic bit hazard();
`ifdef PIPE_FWD_EN
    return ex_regWrite && ex_memRead && reads(ex_write_reg);
`else
    return (ex_regWrite && reads(ex_write_reg)) || (mem_regWrite && reads(mem_write_reg));
`endif
  endfunction

  // Bit order: pc, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_wr, mem_wb_wr
  function automatic logic [6:0] exp_ctrl();
    if (!rst)                 return 7'b0000000;
    if (m_st == 3)            return 7'b0000000;
    if (m_st == 2)            return mem_busy ? 7'b0111100 : 7'b0111111;
    if (mem_busy)             return 7'b0000000;
    if (ex_halt)              return 7'b0111111;
    if (ex_branch_taken)      return 7'b1111111;
    if (hazard())             return 7'b0001111;
    return 7'b1101011;
  endfunction

  task automatic model_reset();
    m_st = 0; m_drain = 0; m_cnt = 0; m_halted = 0;
  endtask

  task automatic set_idle();
    id_rd1_reg = '0; id_rd2_reg = '0; ex_write_reg = '0; mem_write_reg = '0;
    id_rd1_used = 0; id_rd2_used = 0; ex_regWrite = 0; ex_memRead = 0; mem_regWrite = 0;
    ex_branch_taken = 0; ex_halt = 0; mem_busy = 0;
  endtask

  // Advance one clock and move the model with the inputs present before the edge.
  task automatic tick();
    logic [6:0] c;
    c = exp_ctrl();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (!c[6] && m_cnt < CMAX) m_cnt++;
      case (m_st)
        0, 1: begin
          if (mem_busy) m_st = 1;
          else if (ex_halt) begin m_st = 2; m_drain = 2; end
          else m_st = 0;
        end
        2: if (!mem_busy) begin
          m_drain--;
          if (m_drain == 0) begin m_st = 3; m_halted = 1; end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    set_idle();
    model_reset();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    id_rd1_reg = 3'd2; id_rd1_used = 1; ex_write_reg = 3'd2; ex_regWrite = 1;
    ex_branch_taken = 1; ex_halt = 0; mem_busy = 0;
    #2;
    checks++;
    if (act !== 7'b0000000 || halted !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_hold ctrl=%b exp=0000000 halted=%b cnt=%0d exp 0", act, halted, stall_cnt);
    end
    tick();
    rst = 1;
    set_idle();
    #2;
    checks++;
    if (act !== 7'b1101011 || halted !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_release ctrl=%b exp=1101011 halted=%b cnt=%0d", act, halted, stall_cnt);
    end
    tick();
  endtask

  task automatic test_alu_dependency();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      id_rd1_reg = 3'd3; id_rd1_used = 1;
      if (c == 0) begin ex_write_reg = 3'd3; ex_regWrite = 1; end
      if (c == 1) begin mem_write_reg = 3'd3; mem_regWrite = 1; end
      #2;
      checks++;
      if (act !== exp_ctrl() || halted !== m_halted || stall_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL alu_dep cyc%0d ctrl=%b exp=%b cnt=%0d exp=%0d", c, act, exp_ctrl(), stall_cnt, m_cnt);
      end
      tick();
    end
    checks++;
`ifdef PIPE_FWD_EN
    if (stall_cnt !== CW'(0)) begin
`else
    if (stall_cnt !== CW'(2)) begin
`endif
      failures++;
      $display("FAIL alu_dep_cnt cnt=%0d", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      id_rd1_reg = 3'd1; id_rd1_used = 1; id_rd2_reg = 3'd5; id_rd2_used = 1;
      if (c == 0) begin ex_write_reg = 3'd5; ex_regWrite = 1; ex_memRead = 1; end
      if (c == 1) begin mem_write_reg = 3'd5; mem_regWrite = 1; end
      #2;
      checks++;
      if (act !== exp_ctrl() || stall_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL load_use cyc%0d ctrl=%b exp=%b cnt=%0d exp=%0d", c, act, exp_ctrl(), stall_cnt, m_cnt);
      end
      tick();
    end
    checks++;
`ifdef PIPE_FWD_EN
    if (stall_cnt !== CW'(1)) begin
`else
    if (stall_cnt !== CW'(2)) begin
`endif
      failures++;
      $display("FAIL load_use_cnt cnt=%0d", stall_cnt);
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    id_rd1_reg = 3'd4; id_rd1_used = 1; ex_write_reg = 3'd4; ex_regWrite = 1; ex_memRead = 1;
    ex_branch_taken = 1;
    #2;
    checks++;
    if (act !== 7'b1111111 || act !== exp_ctrl()) begin
      failures++;
      $display("FAIL branch_flush ctrl=%b exp=1111111", act);
    end
    tick();
    set_idle();
    #2;
    checks++;
    if (stall_cnt !== '0 || act !== exp_ctrl()) begin
      failures++;
      $display("FAIL branch_cnt cnt=%0d exp=0 ctrl=%b", stall_cnt, act);
    end
    tick();
  endtask

  task automatic test_mem_busy();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      id_rd1_reg = 3'd3; id_rd1_used = 1;
      mem_busy = (c < 3);
      if (c <= 3) begin ex_write_reg = 3'd3; ex_regWrite = 1; ex_memRead = 1; end
      if (c == 4) begin mem_write_reg = 3'd3; mem_regWrite = 1; end
      #2;
      checks++;
      if (act !== exp_ctrl() || stall_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL mem_busy cyc%0d ctrl=%b exp=%b cnt=%0d exp=%0d", c, act, exp_ctrl(), stall_cnt, m_cnt);
      end
      tick();
    end
    checks++;
`ifdef PIPE_FWD_EN
    if (stall_cnt !== CW'(4)) begin
`else
    if (stall_cnt !== CW'(5)) begin
`endif
      failures++;
      $display("FAIL mem_busy_cnt cnt=%0d", stall_cnt);
    end
  endtask

  task automatic test_halt_busy();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      ex_halt  = (c == 0);
      mem_busy = (c == 2);
      #2;
      checks++;
      if (act !== exp_ctrl() || halted !== m_halted || pc_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL halt_busy cyc%0d ctrl=%b exp=%b halted=%b exp=%b", c, act, exp_ctrl(), halted, m_halted);
      end
      checks++;
      if (halted !== (c == 4)) begin
        failures++;
        $display("FAIL halt_timing cyc%0d halted=%b exp=%b", c, halted, (c == 4));
      end
      tick();
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    ex_halt = 1;
    tick();
    set_idle();
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (act !== 7'b0000000 || halted !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL async_reset ctrl=%b exp=0000000 halted=%b cnt=%0d", act, halted, stall_cnt);
    end
    tick();
    rst = 1;
    #2;
    checks++;
    if (act !== 7'b1101011 || halted !== 1'b0 || stall_cnt !== '0) begin
      failures++;
      $display("FAIL after_reset ctrl=%b exp=1101011 halted=%b cnt=%0d", act, halted, stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_halt = 1;
    tick();
    set_idle();
    repeat (25) tick();
    #2;
    checks++;
    if (stall_cnt !== CW'(CMAX) || stall_cnt !== CW'(m_cnt) || halted !== 1'b1 || act !== 7'b0000000) begin
      failures++;
      $display("FAIL saturate cnt=%0d exp=%0d halted=%b ctrl=%b", stall_cnt, CMAX, halted, act);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 60 == 59) do_reset();
      id_rd1_reg      = 3'($urandom_range(0, 7));
      id_rd2_reg      = 3'($urandom_range(0, 7));
      ex_write_reg    = 3'($urandom_range(0, 7));
      mem_write_reg   = 3'($urandom_range(0, 7));
      id_rd1_used     = 1'($urandom_range(0, 1));
      id_rd2_used     = 1'($urandom_range(0, 1));
      ex_regWrite     = 1'($urandom_range(0, 1));
      ex_memRead      = 1'($urandom_range(0, 1));
      mem_regWrite    = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_halt         = ($urandom_range(0, 29) == 0);
      mem_busy        = ($urandom_range(0, 5) == 0);
      #2;
      checks++;
      if (act !== exp_ctrl() || halted !== m_halted || stall_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL random cyc%0d ctrl=%b exp=%b halted=%b exp=%b cnt=%0d exp=%0d",
                 c, act, exp_ctrl(), halted, m_halted, stall_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    rst = 0;
    set_idle();
    model_reset();
    tick();
    test_reset();
    test_alu_dependency();
    test_load_use();
    test_branch_hazard();
    test_mem_busy();
    test_halt_busy();
    test_reset_in_drain();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
